// File: rtl/dtw_scheduler.sv
// dtw_scheduler: runs one DTW job at a time (clear core, run, capture, report)
// Ports: clk/rst (async active-low); job_* request channel (ready only in IDLE);
// core_* drive and observe the DTW core; res_* result channel held until
// res_valid & res_ready; busy = not IDLE; jobs_done = completed handshakes.
module dtw_scheduler #(
  parameter int WIDTH   = 16,
  parameter int QID_W   = 8,
  parameter int CLR_CYC = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [QID_W-1:0] job_qid,
  input  logic [WIDTH-1:0] job_thresh,
  output logic             core_rst,
  output logic             core_running,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_minval,
  input  logic [31:0]      core_position,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [QID_W-1:0] res_qid,
  output logic [WIDTH-1:0] res_minval,
  output logic [31:0]      res_position,
  output logic             res_hit,
  output logic             res_timeout,
  output logic             busy,
  output logic [31:0]      jobs_done
);
  localparam int CNT_W = $clog2((TIMEOUT > CLR_CYC ? TIMEOUT : CLR_CYC) + 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QID_W-1:0] qid_q, qid_d, res_qid_q, res_qid_d;
  logic [WIDTH-1:0] thresh_q, thresh_d, minval_q, minval_d, res_minval_q, res_minval_d;
  logic [31:0] pos_q, pos_d, res_position_q, res_position_d, jobs_done_q, jobs_done_d;
  logic to_q, to_d, res_timeout_q, res_timeout_d, res_hit_q, res_hit_d;
  logic accept, run_end, cap;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (job_valid) begin
        state_d = CLEAR;
        cnt_d = '0;
      end
      CLEAR: begin
        state_d = cnt_q == CLR_LAST ? RUN : CLEAR;
        cnt_d = cnt_q == CLR_LAST ? '0 : cnt_q + 1'b1;
      end
      RUN: begin
        state_d = core_done || cnt_q == TO_LAST ? CAPTURE : RUN;
        cnt_d = core_done || cnt_q == TO_LAST ? cnt_q : cnt_q + 1'b1;
      end
      CAPTURE: state_d = OUTPUT;
      OUTPUT: state_d = res_ready ? IDLE : OUTPUT;
      default: state_d = IDLE;
    endcase
  end
  // done wins over the timeout in the same cycle; a timeout reports all-ones
  always_comb begin
    accept = state_q == IDLE && job_valid;
    run_end = state_q == RUN && (core_done || cnt_q == TO_LAST);
    cap = state_q == CAPTURE;
    qid_d = accept ? job_qid : qid_q;
    thresh_d = accept ? job_thresh : thresh_q;
    minval_d = run_end ? (core_done ? core_minval : '1) : minval_q;
    pos_d = run_end ? (core_done ? core_position : '1) : pos_q;
    to_d = run_end ? !core_done : to_q;
    res_qid_d = cap ? qid_q : res_qid_q;
    res_minval_d = cap ? minval_q : res_minval_q;
    res_position_d = cap ? pos_q : res_position_q;
    res_timeout_d = cap ? to_q : res_timeout_q;
    res_hit_d = cap ? !to_q && minval_q <= thresh_q : res_hit_q;
    jobs_done_d = state_q == OUTPUT && res_ready ? jobs_done_q + 1 : jobs_done_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qid_q <= '0;
      thresh_q <= '0;
      minval_q <= '0;
      pos_q <= '0;
      to_q <= 1'b0;
      res_qid_q <= '0;
      res_minval_q <= '0;
      res_position_q <= '0;
      res_timeout_q <= 1'b0;
      res_hit_q <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      qid_q <= qid_d;
      thresh_q <= thresh_d;
      minval_q <= minval_d;
      pos_q <= pos_d;
      to_q <= to_d;
      res_qid_q <= res_qid_d;
      res_minval_q <= res_minval_d;
      res_position_q <= res_position_d;
      res_timeout_q <= res_timeout_d;
      res_hit_q <= res_hit_d;
      jobs_done_q <= jobs_done_d;
    end
  end
  // rst is folded in so the core is held in reset and no job is offered while rst is low
  always_comb begin
    job_ready = rst && state_q == IDLE;
    core_rst = !rst || state_q == CLEAR;
    core_running = state_q == RUN;
    res_valid = state_q == OUTPUT;
    busy = state_q != IDLE;
    res_qid = res_qid_q;
    res_minval = res_minval_q;
    res_position = res_position_q;
    res_hit = res_hit_q;
    res_timeout = res_timeout_q;
    jobs_done = jobs_done_q;
  end
endmodule
